instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited memory requests, an in-order response queue
// and the IF/ID pipeline register, with redirect flushing of in-flight responses.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_d_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus_4_o
);
    localparam int              PW      = $clog2(QDEPTH);
    localparam int              CW      = $clog2(QDEPTH + 1);
    localparam logic [CW:0]     CREDITS = (CW + 1)'(QDEPTH);
    localparam logic [PW-1:0]   LAST    = PW'(QDEPTH - 1);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    logic [31:0]   fetchPc_q, fetchPc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] dropCount_q, dropCount_d;
    logic [CW-1:0] qCount_q, qCount_d;
    logic [PW-1:0] qHead_q, qHead_d, qTail_q, qTail_d;
    logic [PW-1:0] pcfRd_q, pcfRd_d, pcfWr_q, pcfWr_d;
    logic [31:0]   qInstr_q [QDEPTH];
    logic [31:0]   qPc_q [QDEPTH];
    logic [31:0]   pcFifo_q [QDEPTH];
    logic          ifIdValid_q, ifIdValid_d;
    logic [31:0]   ifIdInstr_q, ifIdInstr_d;
    logic [31:0]   ifIdPc_q, ifIdPc_d;

    logic reqValid, accept, rspKeep, ifIdLoad, qPop, bypass, qPush;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Requests are only issued while queued plus in-flight instructions leave room,
    // so every returning response is guaranteed a queue slot.
    always_comb begin
        reqValid = rst_n & ~redirect_i &
                   (({1'b0, outstanding_q} + {1'b0, qCount_q}) < CREDITS);
        accept   = reqValid & imem_req_ready_i;
        rspKeep  = imem_rsp_valid_i & ~redirect_i & (dropCount_q == '0);
        ifIdLoad = ~ifIdValid_q | ~stall_d_i;
        qPop     = ifIdLoad & (qCount_q != '0);
        bypass   = ifIdLoad & (qCount_q == '0) & rspKeep;
        qPush    = rspKeep & ~bypass;

        fetchPc_d     = fetchPc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid_i);
        dropCount_d   = dropCount_q;
        qCount_d      = qCount_q;
        qHead_d       = qHead_q;
        qTail_d       = qTail_q;
        pcfRd_d       = pcfRd_q;
        pcfWr_d       = pcfWr_q;
        ifIdValid_d   = ifIdValid_q;
        ifIdInstr_d   = ifIdInstr_q;
        ifIdPc_d      = ifIdPc_q;

        if (redirect_i) begin
            fetchPc_d   = redirect_pc_i;
            dropCount_d = outstanding_q - CW'(imem_rsp_valid_i);
            qCount_d    = '0;
            qHead_d     = '0;
            qTail_d     = '0;
            pcfRd_d     = '0;
            pcfWr_d     = '0;
            ifIdValid_d = 1'b0;
            ifIdInstr_d = NOP;
        end else begin
            if (accept) begin
                fetchPc_d = fetchPc_q + 32'd4;
                pcfWr_d   = nextPtr(pcfWr_q);
            end
            if (rspKeep)
                pcfRd_d = nextPtr(pcfRd_q);
            if (imem_rsp_valid_i && (dropCount_q != '0))
                dropCount_d = dropCount_q - CW'(1);
            if (qPush)
                qTail_d = nextPtr(qTail_q);
            if (qPop)
                qHead_d = nextPtr(qHead_q);
            qCount_d = qCount_q + CW'(qPush) - CW'(qPop);
            if (ifIdLoad) begin
                if (qPop) begin
                    ifIdValid_d = 1'b1;
                    ifIdInstr_d = qInstr_q[qHead_q];
                    ifIdPc_d    = qPc_q[qHead_q];
                end else if (bypass) begin
                    ifIdValid_d = 1'b1;
                    ifIdInstr_d = imem_rsp_data_i;
                    ifIdPc_d    = pcFifo_q[pcfRd_q];
                end else begin
                    ifIdValid_d = 1'b0;
                    ifIdInstr_d = NOP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc_q     <= RESET_PC;
            outstanding_q <= '0;
            dropCount_q   <= '0;
            qCount_q      <= '0;
            qHead_q       <= '0;
            qTail_q       <= '0;
            pcfRd_q       <= '0;
            pcfWr_q       <= '0;
            ifIdValid_q   <= 1'b0;
            ifIdInstr_q   <= NOP;
            ifIdPc_q      <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                qInstr_q[i] <= '0;
                qPc_q[i]    <= '0;
                pcFifo_q[i] <= '0;
            end
        end else begin
            fetchPc_q     <= fetchPc_d;
            outstanding_q <= outstanding_d;
            dropCount_q   <= dropCount_d;
            qCount_q      <= qCount_d;
            qHead_q       <= qHead_d;
            qTail_q       <= qTail_d;
            pcfRd_q       <= pcfRd_d;
            pcfWr_q       <= pcfWr_d;
            ifIdValid_q   <= ifIdValid_d;
            ifIdInstr_q   <= ifIdInstr_d;
            ifIdPc_q      <= ifIdPc_d;
            if (qPush) begin
                qInstr_q[qTail_q] <= imem_rsp_data_i;
                qPc_q[qTail_q]    <= pcFifo_q[pcfRd_q];
            end
            if (accept)
                pcFifo_q[pcfWr_q] <= fetchPc_q;
        end
    end

    assign imem_req_valid_o  = reqValid;
    assign imem_req_addr_o   = fetchPc_q;
    assign if_id_valid_o     = ifIdValid_q;
    assign if_id_instr_o     = ifIdInstr_q;
    assign if_id_pc_o        = ifIdPc_q;
    assign if_id_pc_plus_4_o = ifIdPc_q + 32'd4;
endmodule
